flex_slave_timer: RTL
=====================

FLEX_SLAVE_TIMER -- requirements
Module: flex_slave_timer

Interface
REQ-001 Parameter DATA_BITS, default 8, bits per transferred word (legal range 2..16).
REQ-002 Parameter CNT_WIDTH, default 8, width of the word counter.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse: START or repeated START detected on the bus.
REQ-006 stop  in  1  one-cycle pulse: STOP detected on the bus.
REQ-007 rising_edge  in  1  one-cycle pulse: SCL rising edge.
REQ-008 falling_edge  in  1  one-cycle pulse: SCL falling edge.
REQ-009 tx_mode  in  1  1 = slave transmits, so the master drives ACK; 0 = slave receives.
REQ-010 sda_in  in  1  synchronised SDA level.
REQ-011 byte_received  out  1  word complete, high in PREP and CHECK.
REQ-012 ack_prep  out  1  high in PREP.
REQ-013 ack_check  out  1  high in CHECK.
REQ-014 ack_done  out  1  high in DONE.
REQ-015 addr_phase  out  1  high while word_count == 0 and state is not IDLE or HOLD.
REQ-016 master_nack  out  1  high in HOLD.
REQ-017 bit_count  out  $clog2(DATA_BITS+1)  rising edges seen in the current word.
REQ-018 word_count  out  CNT_WIDTH  words completed since the last start.

Function
REQ-019 States: IDLE, START, SHIFT, PREP, CHECK, DONE, HOLD.
REQ-020 Every output is decoded from registered state or counters only; no input-to-output combinational path.
REQ-021 Event priority in every state except IDLE: stop, then start, then edges.
- stop -> IDLE.
- start -> START; clears word_count and bit_count.
REQ-022 IDLE: start -> START; all else ignored.
REQ-023 START: rising_edge -> SHIFT, bit_count = 1.
REQ-024 SHIFT, bit_count < DATA_BITS: rising_edge increments bit_count.
REQ-025 SHIFT, bit_count == DATA_BITS: further rising_edge ignored; falling_edge -> PREP, word_count increments.
REQ-026 word_count saturates at 2^CNT_WIDTH-1 and does not wrap.
REQ-027 PREP: rising_edge -> CHECK; if tx_mode==1, sda_in is sampled into nack_flag in the same cycle.
REQ-028 CHECK: falling_edge -> HOLD if nack_flag==1, else DONE; bit_count cleared.
REQ-029 DONE: rising_edge -> SHIFT, bit_count = 1 (back-to-back words with no start).
REQ-030 HOLD: exits only on stop (-> IDLE) or start (-> START); edges ignored.
REQ-031 rising_edge and falling_edge in the same cycle: rising_edge wins, falling_edge discarded.
REQ-032 stop or start mid-word: the partial word is discarded and word_count is not incremented.
REQ-033 nack_flag clears on entry to START, IDLE or SHIFT.

Reset
REQ-034 n_rst low: state = IDLE; bit_count, word_count and nack_flag = 0; all 1-bit outputs 0; effective immediately, independent of clk.
REQ-035 Deassertion mid-transfer: the block stays in IDLE until the next start pulse.

Structure
REQ-036 State enum typedef flex_timer_state_t lives in shared package i2c_pkg with DATA_BITS/CNT_WIDTH defaults.
REQ-037 bit_count is produced by one flex_counter instance (parametrised width, clear, count_enable, rollover value DATA_BITS); word counter is inline.

Verification (DATA_BITS=8 unless stated)
REQ-038 start, 8 rising + 1 falling, then rising, falling, sda=0 -> PREP, CHECK, DONE; word_count=1; addr_phase drops after PREP.
REQ-039 From DONE, 8 more rising + falling, then stop -> word_count=2, then IDLE with all outputs 0.
REQ-040 tx_mode=1, sda_in=1 at PREP rising edge -> HOLD, master_nack=1; 5 extra edges ignored; start -> START, word_count=0.
REQ-041 start after 4 rising edges -> START, bit_count=0, word_count unchanged=0; stop and start in the same cycle -> IDLE.
REQ-042 DATA_BITS=12, CNT_WIDTH=2: five 12-bit words -> word_count saturates at 3; PREP after the 12th rising edge plus falling.
REQ-043 n_rst asserted between clk edges while in CHECK -> IDLE and all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and defaults for the I2C slave timing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PREP  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_HOLD  = 3'd6
  } flex_timer_state_t;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ============================================================================
// Module      : flex_counter
// Description : Up-counter with synchronous clear, enable and a programmable
//               rollover value (wraps to 1 after reaching rollover_val).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  // Count register: clear dominates, then enabled increment with rollover
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= NUM_CNT_BITS'(1);
      end else begin
        count_out <= count_out + NUM_CNT_BITS'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/flex_slave_timer.sv
// ============================================================================
// Module      : flex_slave_timer
// Description : I2C slave bit/word timing controller. Tracks SCL edges within
//               a word, sequences the ACK slot and counts completed words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flex_slave_timer
  import i2c_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  localparam int BC_WIDTH = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 rising_edge,
  input  logic                 falling_edge,
  input  logic                 tx_mode,
  input  logic                 sda_in,
  output logic                 byte_received,
  output logic                 ack_prep,
  output logic                 ack_check,
  output logic                 ack_done,
  output logic                 addr_phase,
  output logic                 master_nack,
  output logic [BC_WIDTH-1:0]  bit_count,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam logic [BC_WIDTH-1:0]  BITS_FULL = BC_WIDTH'(DATA_BITS);
  localparam logic [CNT_WIDTH-1:0] WORD_MAX  = '1;

  flex_timer_state_t state, next_state;

  logic nack_flag;
  logic rise_ev, fall_ev, bits_full;
  logic go_idle, go_start, word_done;
  logic cnt_clear, cnt_enable;

  // Event qualification: bus conditions first, rising edge masks falling edge
  always_comb begin
    rise_ev    = rising_edge;
    fall_ev    = falling_edge & ~rising_edge;
    bits_full  = (bit_count == BITS_FULL);
    go_idle    = (state != ST_IDLE) && stop;
    go_start   = start && ((state == ST_IDLE) || !stop);
    word_done  = !go_idle && !go_start && (state == ST_SHIFT) && bits_full && fall_ev;
    cnt_clear  = go_idle || go_start || ((state == ST_CHECK) && fall_ev);
    cnt_enable = rise_ev && ((state == ST_START) || (state == ST_DONE) ||
                             ((state == ST_SHIFT) && !bits_full));
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (go_idle) begin
      next_state = ST_IDLE;
    end else if (go_start) begin
      next_state = ST_START;
    end else begin
      case (state)
        ST_START: if (rise_ev) next_state = ST_SHIFT;
        ST_SHIFT: if (bits_full && fall_ev) next_state = ST_PREP;
        ST_PREP:  if (rise_ev) next_state = ST_CHECK;
        ST_CHECK: if (fall_ev) next_state = nack_flag ? ST_HOLD : ST_DONE;
        ST_DONE:  if (rise_ev) next_state = ST_SHIFT;
        default:  next_state = state;
      endcase
    end
  end

  // Output decode from registered state and counters only
  always_comb begin
    byte_received = (state == ST_PREP) || (state == ST_CHECK);
    ack_prep      = (state == ST_PREP);
    ack_check     = (state == ST_CHECK);
    ack_done      = (state == ST_DONE);
    master_nack   = (state == ST_HOLD);
    addr_phase    = (word_count == '0) && (state != ST_IDLE) && (state != ST_HOLD);
  end

  // Bits seen in the current word
  flex_counter #(
    .NUM_CNT_BITS (BC_WIDTH)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_enable),
    .rollover_val (BITS_FULL),
    .count_out    (bit_count)
  );

  // Completed-word counter, saturating at all-ones
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_count <= '0;
    end else if (go_idle || go_start) begin
      word_count <= '0;
    end else if (word_done && (word_count != WORD_MAX)) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  // NACK capture: sampled on the ACK-slot rising edge when the master acks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nack_flag <= 1'b0;
    end else if (go_idle || go_start) begin
      nack_flag <= 1'b0;
    end else if ((state != ST_SHIFT) && (next_state == ST_SHIFT)) begin
      nack_flag <= 1'b0;
    end else if ((state == ST_PREP) && rise_ev && tx_mode) begin
      nack_flag <= sda_in;
    end
  end

endmodule

`default_nettype wire
